// File: rtl/pipe_hazard_ctrl.sv
// Hazard and multi-cycle sequencing control for the 5-stage MIPS pipeline:
// load-use and HI/LO stalls, branch/jump flushes, and the shared mul/div unit.
module pipe_hazard_ctrl #(
    parameter int unsigned MUL_CYCLES = 4,
    parameter int unsigned DIV_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] id_instr,
    input  logic        id_jump,
    input  logic        id_jumpreg,
    input  logic        ex_memread,
    input  logic [4:0]  ex_rt,
    input  logic        ex_branch_taken,
    output logic        pc_we,
    output logic        ifid_we,
    output logic        ifid_flush,
    output logic        idex_bubble,
    output logic        md_start,
    output logic        md_is_div,
    output logic        md_busy,
    output logic        md_done,
    output logic [31:0] stall_cnt
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [5:0] MUL_LOAD = 6'(MUL_CYCLES - 2);
    localparam logic [5:0] DIV_LOAD = 6'(DIV_CYCLES - 2);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_SW    = 6'b101011;

    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [5:0]  funct;
    logic        unused_instr_bits;

    logic        md_op;
    logic        hilo_op;
    logic        uses_rt;
    logic        lu;
    logic        mdh;
    logic        stall;

    logic [1:0]  state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] stall_q, stall_d;

    assign op    = id_instr[31:26];
    assign rs    = id_instr[25:21];
    assign rt    = id_instr[20:16];
    assign funct = id_instr[5:0];
    assign unused_instr_bits = ^id_instr[15:6];

    always_comb begin
        md_op   = (op == OP_RTYPE) && (funct[5:2] == 4'b0110);
        hilo_op = (op == OP_RTYPE) && (funct[5:2] == 4'b0100);
        uses_rt = (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_BNE) || (op == OP_SW);
        lu      = ex_memread && (ex_rt != 5'd0) &&
                  ((ex_rt == rs) || (uses_rt && (ex_rt == rt)));
        mdh     = (md_op || hilo_op) && (state_q != S_IDLE);
        stall   = lu || mdh;
    end

    // Taken branch outranks every stall; a stall outranks a jump redirect.
    always_comb begin
        pc_we       = 1'b1;
        ifid_we     = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        if (ex_branch_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (stall) begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            idex_bubble = 1'b1;
        end else if (id_jump || id_jumpreg) begin
            ifid_flush  = 1'b1;
        end
    end

    assign md_start  = (state_q == S_IDLE) && md_op && !ex_branch_taken && !lu;
    assign md_is_div = funct[1];
    assign md_busy   = (state_q != S_IDLE);
    assign md_done   = (state_q == S_DONE);
    assign stall_cnt = stall_q;

    // BUSY lasts N-1 cycles (cnt runs N-2..0) and DONE adds one, so occupancy is N.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (md_start) begin
                    state_d = S_BUSY;
                    cnt_d   = md_is_div ? DIV_LOAD : MUL_LOAD;
                end
            end
            S_BUSY: begin
                if (cnt_q == 6'd0) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - 6'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        stall_d = stall_q;
        if (stall && !ex_branch_taken) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stall_q <= stall_d;
        end
    end

endmodule
